// File: rtl/pool_pkg.sv
// Shared state encoding, pooling-type codes and datapath widths for the sequential pooling layer.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } pool_state_e;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    localparam int IDX_W = 32;
    localparam int ACC_W = 16;

endpackage

// File: rtl/pool_window_accum.sv
// Window accumulator: running max or running sum over one pooling window, one element per enable.
module pool_window_accum
    import pool_pkg::*;
#(
    parameter int ELEM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  pool_type,
    input  logic [ELEM_WIDTH-1:0] x,
    output logic [ACC_W-1:0]      acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] x_ext_s;

    assign x_ext_s = ACC_W'(x);

    // Next accumulator value; a cleared value of zero also seeds max because elements are unsigned.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = {ACC_W{1'b0}};
        end else if (enable) begin
            if (pool_type == POOL_AVG) begin
                acc_d = acc_q + x_ext_s;
            end else if (x_ext_s > acc_q) begin
                acc_d = x_ext_s;
            end else begin
                acc_d = acc_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pooling_layer_sequential.sv
// Sequential 2-D max/average pooling over a captured flat tensor, one window element per clock.
module pooling_layer_sequential
    import pool_pkg::*;
#(
    parameter int ELEM_WIDTH     = 8,
    parameter int MAX_CHANNELS   = 16,
    parameter int MAX_IMG_HEIGHT = 32,
    parameter int MAX_IMG_WIDTH  = 32,
    parameter int MAX_POOL_SIZE  = 4,
    parameter int MAX_DATA_WIDTH = MAX_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [MAX_DATA_WIDTH-1:0] data_in,
    input  logic [7:0]                pool_size,
    input  logic [7:0]                stride,
    input  logic [7:0]                img_height,
    input  logic [7:0]                img_width,
    input  logic [7:0]                channels,
    input  logic                      pool_type,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      valid_out,
    output logic                      cfg_err,
    output logic [MAX_DATA_WIDTH-1:0] data_out
);

    pool_state_e               state_q, state_d;
    logic [MAX_DATA_WIDTH-1:0] tensor_q, tensor_d;
    logic [MAX_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [7:0]                cfg_k_q, cfg_k_d, cfg_s_q, cfg_s_d;
    logic [7:0]                cfg_h_q, cfg_h_d, cfg_w_q, cfg_w_d, cfg_c_q, cfg_c_d;
    logic                      cfg_type_q, cfg_type_d;
    logic                      err_q, err_d;
    logic [IDX_W-1:0]          ch_q, ch_d, row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]          kr_q, kr_d, kc_q, kc_d, oh_q, oh_d, ow_q, ow_d;
    logic                      valid_out_q, valid_out_d, cfg_err_q, cfg_err_d;
    logic                      in_ready_q, in_ready_d, busy_q, busy_d;

    logic [IDX_W-1:0]          k32_s, s32_s, h32_s, w32_s, c32_s, kk_s, avg_s;
    logic [IDX_W-1:0]          rd_idx_s, wr_idx_s, rd_bit_s, wr_bit_s;
    logic                      illegal_s;
    logic [ELEM_WIDTH-1:0]     x_s, result_s;
    logic [ACC_W-1:0]          acc_s;

    assign k32_s = IDX_W'(cfg_k_q);
    assign s32_s = IDX_W'(cfg_s_q);
    assign h32_s = IDX_W'(cfg_h_q);
    assign w32_s = IDX_W'(cfg_w_q);
    assign c32_s = IDX_W'(cfg_c_q);
    assign kk_s  = k32_s * k32_s;

    assign illegal_s = (cfg_k_q == 8'd0) || (cfg_s_q == 8'd0) || (cfg_c_q == 8'd0) ||
                       (k32_s > IDX_W'(MAX_POOL_SIZE)) || (cfg_k_q > cfg_h_q) || (cfg_k_q > cfg_w_q) ||
                       (h32_s > IDX_W'(MAX_IMG_HEIGHT)) || (w32_s > IDX_W'(MAX_IMG_WIDTH)) ||
                       (c32_s > IDX_W'(MAX_CHANNELS));

    assign rd_idx_s = ch_q * h32_s * w32_s + (row_q * s32_s + kr_q) * w32_s + (col_q * s32_s + kc_q);
    assign rd_bit_s = rd_idx_s * IDX_W'(ELEM_WIDTH);
    assign wr_idx_s = ch_q * oh_q * ow_q + row_q * ow_q + col_q;
    assign wr_bit_s = wr_idx_s * IDX_W'(ELEM_WIDTH);

    // Element fetch, clamped to the latched H*W*C region.
    always_comb begin
        x_s = {ELEM_WIDTH{1'b0}};
        if (rd_idx_s < h32_s * w32_s * c32_s) begin
            x_s = tensor_q[rd_bit_s +: ELEM_WIDTH];
        end else begin
            x_s = {ELEM_WIDTH{1'b0}};
        end
    end

    // Window result: the raw max, or the sum divided by K*K (divisor guarded outside legal configs).
    always_comb begin
        avg_s = IDX_W'(acc_s) / ((kk_s == 32'd0) ? 32'd1 : kk_s);
        if (cfg_type_q == POOL_AVG) begin
            result_s = avg_s[ELEM_WIDTH-1:0];
        end else begin
            result_s = acc_s[ELEM_WIDTH-1:0];
        end
    end

    pool_window_accum #(
        .ELEM_WIDTH(ELEM_WIDTH)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != ACCUM),
        .enable   (state_q == ACCUM),
        .pool_type(cfg_type_q),
        .x        (x_s),
        .acc      (acc_s)
    );

    // FSM next state, counters, capture and writeback.
    always_comb begin
        state_d    = state_q;
        tensor_d   = tensor_q;
        data_out_d = data_out_q;
        cfg_k_d    = cfg_k_q;
        cfg_s_d    = cfg_s_q;
        cfg_h_d    = cfg_h_q;
        cfg_w_d    = cfg_w_q;
        cfg_c_d    = cfg_c_q;
        cfg_type_d = cfg_type_q;
        err_d      = err_q;
        cfg_err_d  = cfg_err_q;
        ch_d       = ch_q;
        row_d      = row_q;
        col_d      = col_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        oh_d       = oh_q;
        ow_d       = ow_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    tensor_d   = data_in;
                    data_out_d = {MAX_DATA_WIDTH{1'b0}};
                    cfg_k_d    = pool_size;
                    cfg_s_d    = stride;
                    cfg_h_d    = img_height;
                    cfg_w_d    = img_width;
                    cfg_c_d    = channels;
                    cfg_type_d = pool_type;
                    err_d      = 1'b0;
                    cfg_err_d  = 1'b0;
                    state_d    = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                err_d = illegal_s;
                oh_d  = illegal_s ? 32'd0 : (h32_s - k32_s) / s32_s + 32'd1;
                ow_d  = illegal_s ? 32'd0 : (w32_s - k32_s) / s32_s + 32'd1;
                ch_d  = 32'd0;
                row_d = 32'd0;
                col_d = 32'd0;
                kr_d  = 32'd0;
                kc_d  = 32'd0;
                state_d = illegal_s ? DONE : ACCUM;
            end
            ACCUM: begin
                if (kc_q == k32_s - 32'd1) begin
                    kc_d = 32'd0;
                    if (kr_q == k32_s - 32'd1) begin
                        kr_d    = 32'd0;
                        state_d = WRITE;
                    end else begin
                        kr_d = kr_q + 32'd1;
                    end
                end else begin
                    kc_d = kc_q + 32'd1;
                end
            end
            WRITE: begin
                data_out_d[wr_bit_s +: ELEM_WIDTH] = result_s;
                state_d = ACCUM;
                if (col_q == ow_q - 32'd1) begin
                    col_d = 32'd0;
                    if (row_q == oh_q - 32'd1) begin
                        row_d = 32'd0;
                        if (ch_q == c32_s - 32'd1) begin
                            ch_d    = 32'd0;
                            state_d = DONE;
                        end else begin
                            ch_d = ch_q + 32'd1;
                        end
                    end else begin
                        row_d = row_q + 32'd1;
                    end
                end else begin
                    col_d = col_q + 32'd1;
                end
            end
            DONE: begin
                cfg_err_d = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_out_d = (state_q == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == ACCUM) || (state_d == WRITE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tensor_q    <= {MAX_DATA_WIDTH{1'b0}};
            data_out_q  <= {MAX_DATA_WIDTH{1'b0}};
            cfg_k_q     <= 8'd0;
            cfg_s_q     <= 8'd0;
            cfg_h_q     <= 8'd0;
            cfg_w_q     <= 8'd0;
            cfg_c_q     <= 8'd0;
            cfg_type_q  <= POOL_MAX;
            err_q       <= 1'b0;
            ch_q        <= 32'd0;
            row_q       <= 32'd0;
            col_q       <= 32'd0;
            kr_q        <= 32'd0;
            kc_q        <= 32'd0;
            oh_q        <= 32'd0;
            ow_q        <= 32'd0;
            valid_out_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tensor_q    <= tensor_d;
            data_out_q  <= data_out_d;
            cfg_k_q     <= cfg_k_d;
            cfg_s_q     <= cfg_s_d;
            cfg_h_q     <= cfg_h_d;
            cfg_w_q     <= cfg_w_d;
            cfg_c_q     <= cfg_c_d;
            cfg_type_q  <= cfg_type_d;
            err_q       <= err_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            oh_q        <= oh_d;
            ow_q        <= ow_d;
            valid_out_q <= valid_out_d;
            cfg_err_q   <= cfg_err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign valid_out = valid_out_q;
    assign cfg_err   = cfg_err_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_pooling_layer_sequential.sv
// Directed self-checking bench for pooling_layer_sequential with hand-computed expectations.
module tb_pooling_layer_sequential;

    localparam int MDW = 16 * 32 * 32 * 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           valid_in;
    logic [MDW-1:0] din;
    logic [7:0]     pool_size, stride, img_height, img_width, channels;
    logic           pool_type;
    logic           in_ready, busy, valid_out, cfg_err;
    logic [MDW-1:0] data_out;

    int passed = 0;
    int total  = 0;

    pooling_layer_sequential dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (din),
        .pool_size (pool_size),
        .stride    (stride),
        .img_height(img_height),
        .img_width (img_width),
        .channels  (channels),
        .pool_type (pool_type),
        .in_ready  (in_ready),
        .busy      (busy),
        .valid_out (valid_out),
        .cfg_err   (cfg_err),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] out_byte(input int idx);
        return data_out[idx*8 +: 8];
    endfunction

    // Capture one job on the next edge, scramble the config, then wait for valid_out.
    task automatic launch(input logic [7:0] k, s, h, w, c, input logic t, output int lat);
        pool_size = k; stride = s; img_height = h; img_width = w; channels = c; pool_type = t;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        pool_size = 8'd0; stride = 8'd0; img_height = 8'd0; img_width = 8'd0; channels = 8'd0;
        pool_type = ~t;
        lat = 0;
        while (valid_out !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic fill_ramp(input int n);
        din = '0;
        for (int i = 0; i < n; i++) din[i*8 +: 8] = 8'(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; valid_in = 1'b0; din = '0; pool_type = 1'b0;
        pool_size = 8'd0; stride = 8'd0; img_height = 8'd0; img_width = 8'd0; channels = 8'd0;
        #3 rst_n = 1'b0;
        #4;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_err); else passed++;
        total++; if (data_out !== '0) $display("FAIL reset_data_out: got nonzero want 0"); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        int lat;
        logic [7:0] exp_v [4];
        exp_v = '{8'd5, 8'd7, 8'd13, 8'd15};
        fill_ramp(16);
        launch(8'd2, 8'd2, 8'd4, 8'd4, 8'd1, 1'b0, lat);
        total++; if (lat !== 22) $display("FAIL max_latency: got %0d want 22", lat); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL max_cfg_err: got %b want 0", cfg_err); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_byte(i) !== exp_v[i]) $display("FAIL max_out[%0d]: got %0d want %0d", i, out_byte(i), exp_v[i]);
            else passed++;
        end
        total++; if ((data_out >> 32) !== '0) $display("FAIL max_upper_zero: got nonzero want 0"); else passed++;
        @(posedge clk); #1;
        total++; if (valid_out !== 1'b0) $display("FAIL max_pulse_width: got %b want 0", valid_out); else passed++;
    endtask

    task automatic test_avg();
        int lat;
        din = '0;
        for (int i = 0; i < 16; i++) din[i*8 +: 8] = 8'd255;
        launch(8'd2, 8'd2, 8'd4, 8'd4, 8'd1, 1'b1, lat);
        total++; if (lat !== 22) $display("FAIL avg_latency: got %0d want 22", lat); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_byte(i) !== 8'd255) $display("FAIL avg_sat_out[%0d]: got %0d want 255", i, out_byte(i));
            else passed++;
        end
        din[0*8 +: 8] = 8'd1; din[1*8 +: 8] = 8'd2; din[4*8 +: 8] = 8'd3; din[5*8 +: 8] = 8'd4;
        launch(8'd2, 8'd2, 8'd4, 8'd4, 8'd1, 1'b1, lat);
        total++; if (out_byte(0) !== 8'd2) $display("FAIL avg_trunc_out[0]: got %0d want 2", out_byte(0)); else passed++;
        total++; if (out_byte(1) !== 8'd255) $display("FAIL avg_trunc_out[1]: got %0d want 255", out_byte(1)); else passed++;
    endtask

    task automatic test_multi_channel();
        int lat;
        logic [7:0] exp_v [3];
        exp_v = '{8'd1, 8'd2, 8'd9};
        din = '0;
        for (int i = 0; i < 12; i++) din[i*8 +: 8] = exp_v[i/4];
        launch(8'd2, 8'd1, 8'd2, 8'd2, 8'd3, 1'b0, lat);
        total++; if (lat !== 17) $display("FAIL mc_latency: got %0d want 17", lat); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_byte(i) !== exp_v[i]) $display("FAIL mc_out[%0d]: got %0d want %0d", i, out_byte(i), exp_v[i]);
            else passed++;
        end
        total++; if ((data_out >> 24) !== '0) $display("FAIL mc_upper_zero: got nonzero want 0"); else passed++;
    endtask

    task automatic test_overlap();
        int lat;
        logic [7:0] exp_max [9];
        logic [7:0] exp_avg [9];
        exp_max = '{8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24};
        exp_avg = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
        fill_ramp(25);
        launch(8'd3, 8'd1, 8'd5, 8'd5, 8'd1, 1'b0, lat);
        total++; if (lat !== 92) $display("FAIL ovl_latency: got %0d want 92", lat); else passed++;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (out_byte(i) !== exp_max[i]) $display("FAIL ovl_max[%0d]: got %0d want %0d", i, out_byte(i), exp_max[i]);
            else passed++;
        end
        launch(8'd3, 8'd1, 8'd5, 8'd5, 8'd1, 1'b1, lat);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (out_byte(i) !== exp_avg[i]) $display("FAIL ovl_avg[%0d]: got %0d want %0d", i, out_byte(i), exp_avg[i]);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [7:0] ik [5], is [5], ih [5], iw [5], ic [5];
        ik = '{8'd0, 8'd2, 8'd6, 8'd3, 8'd2};
        is = '{8'd2, 8'd0, 8'd1, 8'd1, 8'd1};
        ih = '{8'd4, 8'd4, 8'd8, 8'd2, 8'd4};
        iw = '{8'd4, 8'd4, 8'd8, 8'd2, 8'd4};
        ic = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
        fill_ramp(64);
        for (int i = 0; i < 5; i++) begin
            launch(ik[i], is[i], ih[i], iw[i], ic[i], 1'b0, lat);
            total++; if (lat !== 2) $display("FAIL ill%0d_latency: got %0d want 2", i, lat); else passed++;
            total++; if (cfg_err !== 1'b1) $display("FAIL ill%0d_cfg_err: got %b want 1", i, cfg_err); else passed++;
            total++; if (data_out !== '0) $display("FAIL ill%0d_data_out: got nonzero want 0", i); else passed++;
        end
    endtask

    task automatic test_robustness();
        int lat;
        logic [7:0] exp_v [4];
        exp_v = '{8'd5, 8'd7, 8'd13, 8'd15};
        fill_ramp(16);
        pool_size = 8'd2; stride = 8'd2; img_height = 8'd4; img_width = 8'd4; channels = 8'd1; pool_type = 1'b0;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        total++; if (busy !== 1'b1) $display("FAIL rob_busy: got %b want 1", busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rob_in_ready: got %b want 0", in_ready); else passed++;
        din = '0; pool_size = 8'd0; pool_type = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1; lat++;
        valid_in = 1'b0;
        while (valid_out !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 22) $display("FAIL rob_latency: got %0d want 22", lat); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL rob_cfg_err: got %b want 0", cfg_err); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_byte(i) !== exp_v[i]) $display("FAIL rob_out[%0d]: got %0d want %0d", i, out_byte(i), exp_v[i]);
            else passed++;
        end
        // Reset in the middle of a job, after the first window has been written.
        fill_ramp(16);
        pool_size = 8'd2; stride = 8'd2; img_height = 8'd4; img_width = 8'd4; channels = 8'd1; pool_type = 1'b0;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        total++; if (out_byte(0) !== 8'd5) $display("FAIL rst_pre_out[0]: got %0d want 5", out_byte(0)); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (data_out !== '0) $display("FAIL rst_mid_data_out: got nonzero want 0"); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL rst_mid_valid_out: got %b want 0", valid_out); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        launch(8'd2, 8'd2, 8'd4, 8'd4, 8'd1, 1'b0, lat);
        total++; if (lat !== 22) $display("FAIL rst_after_latency: got %0d want 22", lat); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_byte(i) !== exp_v[i]) $display("FAIL rst_after_out[%0d]: got %0d want %0d", i, out_byte(i), exp_v[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_avg();
        test_multi_channel();
        test_overlap();
        test_illegal();
        test_robustness();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
